ram_requester: RTL and testbench

Initiator-side controller for the byte-addressed physical RAM. It accepts byte, halfword and word load/store requests from a client (MMU or core) over a valid/ready handshake and drives the RAM's address / write-enable / write-value / read-value port. Sub-word stores are performed as read-modify-write because the RAM always transfers four little-endian bytes starting at the given address. One request is in flight at a time.

---
 rtl/ram_requester.sv | 136 +++++++++++++
 tb/tb_ram_requester.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_requester.sv
// Initiator-side controller for a byte-addressed RAM: byte/half/word loads and stores over a
// valid/ready handshake, with sub-word stores performed as read-modify-write of a 4-byte word.
module ram_requester #(
  parameter int unsigned RAM_BYTES = 65536
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_error,
  output logic [31:0] resp_rdata,
  output logic [31:0] ram_address,
  output logic        ram_write_enable,
  output logic [31:0] ram_write_value,
  input  logic [31:0] ram_read_value
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_RESP
  } state_t;

  localparam logic [31:0] LAST_ADDR = 32'(RAM_BYTES - 4);

  state_t      r_state;
  state_t      w_next;
  logic        r_write;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [31:0] r_addr;
  logic [15:0] r_wdata;
  logic        r_err;
  logic [31:0] r_wbuf;
  logic [31:0] r_rdata;

  logic        w_accept;
  logic        w_req_err;
  logic        w_word_store;
  logic [31:0] w_ext;
  logic [31:0] w_merge;

  assign w_accept     = req_valid && (r_state == S_IDLE);
  assign w_word_store = req_write && (req_size == 2'd2);

  // The address being checked here is the one latched on this same edge.
  always_comb begin
    w_req_err = 1'b0;
    if (req_size == 2'd3)                          w_req_err = 1'b1;
    if ((req_size == 2'd1) && req_addr[0])         w_req_err = 1'b1;
    if ((req_size == 2'd2) && (req_addr[1:0] != 2'b00)) w_req_err = 1'b1;
    if (req_addr > LAST_ADDR)                      w_req_err = 1'b1;
  end

  always_comb begin
    w_ext = ram_read_value;
    case (r_size)
      2'd0:    w_ext = {{24{r_signed & ram_read_value[7]}}, ram_read_value[7:0]};
      2'd1:    w_ext = {{16{r_signed & ram_read_value[15]}}, ram_read_value[15:0]};
      default: w_ext = ram_read_value;
    endcase
  end

  always_comb begin
    w_merge = {ram_read_value[31:16], r_wdata[15:0]};
    if (r_size == 2'd0) w_merge = {ram_read_value[31:8], r_wdata[7:0]};
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_req_err)         w_next = S_RESP;
          else if (w_word_store) w_next = S_WRITE;
          else                   w_next = S_READ;
        end
      end
      S_READ:  w_next = S_WAIT;
      S_WAIT:  w_next = r_write ? S_WRITE : S_RESP;
      S_WRITE: w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_write  <= 1'b0;
      r_size   <= '0;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_err    <= 1'b0;
      r_wbuf   <= '0;
      r_rdata  <= '0;
    end else begin
      if (w_accept) begin
        r_write  <= req_write;
        r_size   <= req_size;
        r_signed <= req_signed;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata[15:0];
        r_err    <= w_req_err;
        r_rdata  <= '0;
        if (w_word_store && !w_req_err) r_wbuf <= req_wdata;
      end
      if (r_state == S_WAIT) begin
        if (r_write) r_wbuf  <= w_merge;
        else         r_rdata <= w_ext;
      end
    end
  end

  assign req_ready        = (r_state == S_IDLE);
  assign resp_valid       = (r_state == S_RESP);
  assign resp_error       = (r_state == S_RESP) && r_err;
  assign resp_rdata       = r_rdata;
  assign ram_address      = r_addr;
  assign ram_write_enable = (r_state == S_WRITE);
  assign ram_write_value  = r_wbuf;

endmodule

// File: tb/tb_ram_requester.sv
// Directed bench for ram_requester: behavioural byte RAM, table of request vectors with
// hand-computed results, plus reset sequences (idle, mid-run, during the write cycle).
module tb_ram_requester;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_error;
  logic [31:0] resp_rdata;
  logic [31:0] ram_address;
  logic        ram_write_enable;
  logic [31:0] ram_write_value;
  logic [31:0] ram_read_value;

  int checks = 0;
  int errors = 0;

  ram_requester #(.RAM_BYTES(65536)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_size         (req_size),
    .req_signed       (req_signed),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_error       (resp_error),
    .resp_rdata       (resp_rdata),
    .ram_address      (ram_address),
    .ram_write_enable (ram_write_enable),
    .ram_write_value  (ram_write_value),
    .ram_read_value   (ram_read_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: registered read, 4-byte little-endian write, plus a bench poke port.
  logic [7:0]  mem [0:65535];
  logic        poke_en;
  logic [15:0] poke_addr;
  logic [7:0]  poke_data;
  logic [15:0] ma;

  always @(posedge clk) begin
    ma = ram_address[15:0];
    if (poke_en) begin
      mem[poke_addr] = poke_data;
    end else if (ram_write_enable) begin
      if (ram_address <= 32'd65532) begin
        mem[ma]      = ram_write_value[7:0];
        mem[ma + 1]  = ram_write_value[15:8];
        mem[ma + 2]  = ram_write_value[23:16];
        mem[ma + 3]  = ram_write_value[31:24];
      end
    end else begin
      if (ram_address <= 32'd65532)
        ram_read_value <= {mem[ma + 3], mem[ma + 2], mem[ma + 1], mem[ma]};
      else
        ram_read_value <= 32'h0;
    end
  end

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    int unsigned lat;
    logic        err;
    logic [31:0] rdata;
    int unsigned nwr;
    logic [31:0] wval;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic wr, logic [1:0] size, logic sgn, logic [31:0] addr,
                              logic [31:0] wdata, int unsigned lat, logic err,
                              logic [31:0] rdata, int unsigned nwr, logic [31:0] wval);
    vec_t v;
    v.wr = wr; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.lat = lat; v.err = err; v.rdata = rdata; v.nwr = nwr; v.wval = wval;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic issue(input logic wr, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
    int unsigned n;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1; req_write = wr; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic run_req(input logic wr, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int unsigned lat, output logic [31:0] rdata,
                         output logic err, output int unsigned nwr, output logic [31:0] wval);
    issue(wr, size, sgn, addr, wdata);
    lat = 1; nwr = 0; wval = 32'h0;
    while (!resp_valid && lat < 16) begin
      if (ram_write_enable) begin
        nwr++;
        wval = ram_write_value;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    rdata = resp_rdata;
    err   = resp_error;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
    chk({tag, "_rvalid"}, {31'b0, resp_valid}, 32'd0);
    chk({tag, "_rerr"}, {31'b0, resp_error}, 32'd0);
    chk({tag, "_rdata"}, resp_rdata, 32'h0);
    chk({tag, "_addr"}, ram_address, 32'h0);
    chk({tag, "_we"}, {31'b0, ram_write_enable}, 32'd0);
    chk({tag, "_wval"}, ram_write_value, 32'h0);
  endtask

  initial begin
    int unsigned lat, nwr, strobes, seen;
    logic [31:0] rdata, wval;
    logic        err;

    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; poke_en = 1'b0; poke_addr = '0; poke_data = '0;

    #2;
    chk_reset_outputs("por");

    poke(16'h0020, 8'h11); poke(16'h0021, 8'h22); poke(16'h0022, 8'h33); poke(16'h0023, 8'h44);
    poke(16'hFFFC, 8'h01); poke(16'hFFFD, 8'h02); poke(16'hFFFE, 8'h03); poke(16'hFFFF, 8'h04);

    @(negedge clk);
    reset = 1'b1;
    strobes = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (ram_write_enable) strobes++;
    end
    chk("idle_ready", {31'b0, req_ready}, 32'd1);
    chk("idle_strobes", strobes, 32'd0);

    //        wr    size  sgn   addr          wdata         lat err rdata         nwr wval
    vecs.push_back(mk(1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hDEADBEEF, 2, 1'b0, 32'h0,        1, 32'hDEADBEEF));
    vecs.push_back(mk(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,        3, 1'b0, 32'hDEADBEEF, 0, 32'h0));
    vecs.push_back(mk(1'b1, 2'd0, 1'b0, 32'h0000_0020, 32'hFFFFFFA5, 4, 1'b0, 32'h0,        1, 32'h443322A5));
    vecs.push_back(mk(1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'h0,        3, 1'b0, 32'h443322A5, 0, 32'h0));
    vecs.push_back(mk(1'b1, 2'd1, 1'b0, 32'h0000_0020, 32'hABCDFF80, 4, 1'b0, 32'h0,        1, 32'h4433FF80));
    vecs.push_back(mk(1'b0, 2'd0, 1'b1, 32'h0000_0020, 32'h0,        3, 1'b0, 32'hFFFFFF80, 0, 32'h0));
    vecs.push_back(mk(1'b0, 2'd0, 1'b0, 32'h0000_0020, 32'h0,        3, 1'b0, 32'h00000080, 0, 32'h0));
    vecs.push_back(mk(1'b0, 2'd1, 1'b1, 32'h0000_0020, 32'h0,        3, 1'b0, 32'hFFFFFF80, 0, 32'h0));
    vecs.push_back(mk(1'b0, 2'd1, 1'b0, 32'h0000_0020, 32'h0,        3, 1'b0, 32'h0000FF80, 0, 32'h0));
    vecs.push_back(mk(1'b0, 2'd0, 1'b1, 32'h0000_0021, 32'h0,        3, 1'b0, 32'hFFFFFFFF, 0, 32'h0));
    vecs.push_back(mk(1'b0, 2'd1, 1'b0, 32'h0000_0021, 32'h0,        1, 1'b1, 32'h0,        0, 32'h0));
    vecs.push_back(mk(1'b1, 2'd2, 1'b0, 32'h0000_0022, 32'h12345678, 1, 1'b1, 32'h0,        0, 32'h0));
    vecs.push_back(mk(1'b0, 2'd3, 1'b0, 32'h0000_0020, 32'h0,        1, 1'b1, 32'h0,        0, 32'h0));
    vecs.push_back(mk(1'b0, 2'd2, 1'b0, 32'h0000_FFFD, 32'h0,        1, 1'b1, 32'h0,        0, 32'h0));
    vecs.push_back(mk(1'b0, 2'd2, 1'b0, 32'h0000_FFFC, 32'h0,        3, 1'b0, 32'h04030201, 0, 32'h0));
    vecs.push_back(mk(1'b1, 2'd0, 1'b0, 32'h0000_FFFC, 32'h1234565A, 4, 1'b0, 32'h0,        1, 32'h0403025A));
    vecs.push_back(mk(1'b1, 2'd0, 1'b0, 32'h0000_FFFD, 32'h00000077, 1, 1'b1, 32'h0,        0, 32'h0));
    vecs.push_back(mk(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'h0,        1, 1'b1, 32'h0,        0, 32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      run_req(vecs[i].wr, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
              lat, rdata, err, nwr, wval);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_error", i), {31'b0, err}, {31'b0, vecs[i].err});
      chk($sformatf("v%0d_rdata", i), rdata, vecs[i].rdata);
      chk($sformatf("v%0d_strobes", i), nwr, vecs[i].nwr);
      if (vecs[i].nwr != 0) chk($sformatf("v%0d_wval", i), wval, vecs[i].wval);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_pulse_end", i), {30'b0, resp_valid, req_ready}, 32'd1);
    end

    chk("mem_10", {mem[16'h13], mem[16'h12], mem[16'h11], mem[16'h10]}, 32'hDEADBEEF);
    chk("mem_20", {mem[16'h23], mem[16'h22], mem[16'h21], mem[16'h20]}, 32'h4433FF80);
    chk("mem_fffc", {mem[16'hFFFF], mem[16'hFFFE], mem[16'hFFFD], mem[16'hFFFC]}, 32'h0403025A);

    // Asynchronous reset in the middle of an idle cycle.
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    reset = 1'b1;

    // Reset landing inside the write cycle of a byte store.
    issue(1'b1, 2'd0, 1'b0, 32'h0000_0030, 32'h000000C3);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (ram_write_enable) begin
        seen = 1;
        break;
      end
      if (resp_valid) break;
      @(posedge clk);
      #1;
    end
    chk("wrst_in_write", seen, 32'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("wrst_we_drop", {31'b0, ram_write_enable}, 32'd0);
    chk("wrst_ready", {31'b0, req_ready}, 32'd1);
    strobes = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid || ram_write_enable) strobes++;
    end
    reset = 1'b1;
    chk("wrst_no_resp", strobes, 32'd0);

    run_req(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0, lat, rdata, err, nwr, wval);
    chk("after_rst_latency", lat, 32'd3);
    chk("after_rst_rdata", rdata, 32'hDEADBEEF);
    chk("after_rst_error", {31'b0, err}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
